// File: rtl/div_unit.sv
// div_unit: multicycle signed integer divider (restoring, one quotient bit
// per clock). Quotient goes to lo, remainder to hi; division truncates toward
// zero and the remainder takes the sign of the dividend.
// Optional feature macro: DIV_UNSIGNED_EN adds the div_unsigned port, which
// selects unsigned division with the same latency.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation, mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             uns_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;

`ifdef DIV_UNSIGNED_EN
  assign uns_s = div_unsigned;
`else
  assign uns_s = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // If the shifted remainder has its top bit set it already exceeds any
  // WIDTH-bit divisor; otherwise no borrow in diff_s means it fits.
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_q};
    fits_s      = rem_shift_s[WIDTH] | ~diff_s[WIDTH];
  end

  // Next-state and datapath update for the IDLE/CALC/SIGN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_quo_d = ~uns_s & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = ~uns_s & a[WIDTH-1];
          dvd_d     = (~uns_s & a[WIDTH-1]) ? neg_w(a) : a;
          dvs_d     = (~uns_s & b[WIDTH-1]) ? neg_w(b) : b;
          rem_d     = ZERO_W;
          if (b == ZERO_W) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_LAST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = fits_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], fits_s};
        if (cnt_q == CNT_ZERO) begin
          state_d = S_SIGN;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_SIGN: begin
        lo_d    = neg_quo_q ? neg_w(dvd_q) : dvd_q;
        hi_d    = neg_rem_q ? neg_w(rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Entered from SIGN with done already raised; entered straight from
        // IDLE (zero divisor) with done still low, so raise done+div0 now.
        if (!done_q) begin
          done_d  = 1'b1;
          div0_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
  end

  // State and output registers; synchronous reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      rem_q     <= ZERO_W;
      dvd_q     <= ZERO_W;
      dvs_q     <= ZERO_W;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit (WIDTH=32), plus
// hand-written sequences for ignored starts and mid-operation reset.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         uns;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int failures;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (uns),
`endif
    .busy         (busy),
    .done         (done),
    .div0         (div0),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         uns;
    logic         disturb;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    logic         exp_div0;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check latency and results.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    int lat;
    lat = (v.b == 32'h0) ? 2 : W + 2;
    a     = v.a;
    b     = v.b;
    uns   = v.uns;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    if (v.b != 32'h0) chk({tag, " busy_after_start"}, {31'h0, busy}, 32'h1);
    while (!done && n < 100) begin
      if (v.disturb && n == 5) begin
        start = 1'b1;
        a     = 32'h0000_0001;
        b     = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, {31'h0, done}, 32'h1);
    chk({tag, " latency"}, n, lat);
    chk({tag, " lo"}, lo, v.exp_lo);
    chk({tag, " hi"}, hi, v.exp_hi);
    chk({tag, " div0"}, {31'h0, div0}, {31'h0, v.exp_div0});
    chk({tag, " busy_at_done"}, {31'h0, busy}, 32'h0);
    if (v.disturb) begin
      start = 1'b1;
      a     = 32'h0000_0064;
      b     = 32'h0000_0003;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " done_pulse_ends"}, {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    uns      = 1'b0;
    reset    = 1'b1;

    //              a              b              uns   dist  lo             hi             div0
    vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'd5,         32'd0,         1'b0, 1'b0, 32'd14,        32'd2,         1'b1};
    vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b0};
    vecs[4]  = '{32'hFFFF_FF9C, 32'd7,         1'b0, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{32'd100,       32'hFFFF_FFF9, 1'b0, 1'b1, 32'hFFFF_FFF2, 32'd2,         1'b0};
    vecs[6]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b0, 32'd14,        32'hFFFF_FFFE, 1'b0};
    vecs[7]  = '{32'd7,         32'd100,       1'b0, 1'b0, 32'd0,         32'd7,         1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0,         1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd1,         32'd0,         1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 32'd1,         32'd0,         1'b1};
`ifdef DIV_UNSIGNED_EN
    vecs[11] = '{32'hFFFF_FFFF, 32'd2,         1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0};
`else
    vecs[11] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF, 1'b0};
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset div0", {31'h0, div0}, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-operation: a second start is ignored, then reset discards the op.
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("midop busy_before_reset", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midop reset busy", {31'h0, busy}, 32'h0);
    chk("midop reset done", {31'h0, done}, 32'h0);
    chk("midop reset hi", hi, 32'h0);
    chk("midop reset lo", lo, 32'h0);
    run_op('{32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 32'd0, 1'b0}, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
